alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority (port 0 wins).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports req0/req1  input  1 each  operation request from requester 0/1.
REQ-005 SHALL have ports a0,b0/a1,b1  input  32 each  operands of requester 0/1.
REQ-006 SHALL have ports oper0/oper1  input  4 each  ALU operation code (EXE_ALU_* from mips_define.vh); sign0/sign1  input  1 each  signed-compare/arithmetic-shift select.
REQ-007 SHALL have port flush  input  1  synchronous abort of the in-flight operation.
REQ-008 SHALL have ports alu_a,alu_b  output  32 each; alu_oper  output  4; alu_sign  output  1; all driving the shared ALU instance.
REQ-009 SHALL have port alu_result  input  32  combinational result returned by the shared ALU.
REQ-010 SHALL have ports gnt0/gnt1  output  1 each  one-cycle pulse: request accepted.
REQ-011 SHALL have ports done0/done1  output  1 each  one-cycle pulse: result valid for that requester.
REQ-012 SHALL have ports result  output  32  registered result; busy  output  1  high while in EXEC.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and EXEC.
REQ-014 In IDLE, at a rising edge where req0 or req1 is high, SHALL latch the winner's a, b, oper and sign into operand registers, record the owner, pulse the winner's gnt in the following cycle, and enter EXEC.
REQ-015 In EXEC, SHALL drive alu_a/alu_b/alu_oper/alu_sign from the operand registers; in IDLE SHALL drive them to zero.
REQ-016 At the edge leaving EXEC, SHALL register alu_result into result, pulse the owner's done for one cycle, and return to IDLE.
REQ-017 Latency SHALL be: request sampled at edge N; gnt high during cycle N+1; done and result valid during cycle N+2.
REQ-018 Throughput SHALL be at most one accepted operation per two cycles; no request is sampled while in EXEC.
REQ-019 A requester SHALL hold req and its operands stable until it observes its gnt; the arbiter SHALL ignore requests during EXEC.
REQ-020 On simultaneous req0 and req1 with FAIR=1, SHALL grant the port not granted most recently; with FAIR=0, SHALL grant port 0.
REQ-021 The last-grant register SHALL update only on acceptance, and SHALL hold a value that makes port 0 win the first contention after reset.
REQ-022 gnt0 and gnt1 SHALL never be high together; done0 and done1 SHALL never be high together.
REQ-023 result SHALL hold its last value until the next done; it SHALL NOT change on flush or in IDLE.
REQ-024 flush high at an edge in EXEC SHALL return the FSM to IDLE with no done pulse and result unchanged; a gnt already pulsed is not retracted.
REQ-025 flush high at an edge in IDLE SHALL suppress acceptance at that edge; requests stay pending.
REQ-026 busy SHALL equal (state == EXEC).

Reset
REQ-027 While rst is high, SHALL force: state IDLE; gnt0/1, done0/1 and busy 0; result 0; operand registers 0; last-grant set so port 0 wins next contention.
REQ-028 rst asserted during EXEC SHALL abort the operation immediately with no done pulse after release.
REQ-029 After rst deasserts, the first acceptance SHALL occur at the first rising edge with a request present.

Verification
REQ-030 Single ADD: req0, a0=5, b0=7, oper0=EXE_ALU_ADD at edge 0 -> gnt0 in cycle 1; done0=1 and result=12 in cycle 2; busy=1 in cycle 1 only.
REQ-031 Contention, FAIR=1: req0 and req1 held high -> grants alternate 0,1,0,1; result/done owner matches each grant (a1=0xFFFFFFFF, b1=1, SUB -> result 0xFFFFFFFE on port 1).
REQ-032 FAIR=0: both requests held for 4 operations -> all grants go to port 0; gnt1 never pulses.
REQ-033 Signed SLT: a0=0xFFFFFFFF, b0=1, sign0=1 -> result 1; sign0=0 -> result 0.
REQ-034 Flush: flush in the EXEC cycle of an op -> no done; result keeps its prior value (12); the next request completes normally.
REQ-035 Reset: rst pulsed mid-EXEC -> no done; outputs are 0; the first contention after release grants port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. A request seen in IDLE
// is latched, granted and executed in the next cycle (EXEC). The ALU result is
// registered at the edge that leaves EXEC, and the owner gets a done pulse.
// The operation takes two cycles, so at most one operation is accepted every
// two cycles.
//
// Parameters
//   FAIR        1 = round-robin between ports, 0 = port 0 always wins
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   req0/req1   operation requests (held until the matching gnt is seen)
//   a*/b*       32-bit operands, oper* 4-bit ALU opcode, sign* signed select
//   flush       synchronous abort: cancels EXEC, blocks acceptance in IDLE
//   alu_a/alu_b/alu_oper/alu_sign  drive the shared ALU (zero in IDLE)
//   alu_result  combinational result from the shared ALU
//   gnt0/gnt1   one-cycle pulse, request accepted
//   done0/done1 one-cycle pulse, result valid for that requester
//   result      registered ALU result, held until the next done
//   busy        high while in EXEC
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [3:0]  oper0,
    input  logic [3:0]  oper1,
    input  logic        sign0,
    input  logic        sign1,
    input  logic        flush,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_oper,
    output logic        alu_sign,
    input  logic [31:0] alu_result,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        accept_s;
    logic        win_s;          // 0 = port 0 wins, 1 = port 1 wins
    logic        finish_s;       // EXEC completes with a result
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic [3:0]  op_oper_r;
    logic        op_sign_r;
    logic        owner_r;
    logic        last_grant_r;   // port granted most recently
    logic        gnt0_r;
    logic        gnt1_r;
    logic        done0_r;
    logic        done1_r;
    logic [31:0] result_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, arbitration and completion decode
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        win_s       = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!flush && (req0 || req1)) begin
                    accept_s    = 1'b1;
                    state_nxt_s = EXEC;
                    if (req0 && req1) begin
                        // Last-grant resets to 1 so port 0 wins the first contention.
                        if (FAIR != 0) begin
                            win_s = ~last_grant_r;
                        end else begin
                            win_s = 1'b0;
                        end
                    end else begin
                        win_s = req1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                state_nxt_s = IDLE;
                finish_s    = ~flush;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // ALU drive: operand registers while executing, zero otherwise
    always_comb begin
        if (state_r == EXEC) begin
            alu_a    = op_a_r;
            alu_b    = op_b_r;
            alu_oper = op_oper_r;
            alu_sign = op_sign_r;
        end else begin
            alu_a    = 32'd0;
            alu_b    = 32'd0;
            alu_oper = 4'd0;
            alu_sign = 1'b0;
        end
    end

    // Operand capture, ownership, grant/done pulses and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            op_oper_r    <= 4'd0;
            op_sign_r    <= 1'b0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            gnt0_r       <= 1'b0;
            gnt1_r       <= 1'b0;
            done0_r      <= 1'b0;
            done1_r      <= 1'b0;
            result_r     <= 32'd0;
        end else begin
            gnt0_r  <= accept_s & ~win_s;
            gnt1_r  <= accept_s & win_s;
            done0_r <= finish_s & ~owner_r;
            done1_r <= finish_s & owner_r;
            if (accept_s) begin
                op_a_r       <= win_s ? a1 : a0;
                op_b_r       <= win_s ? b1 : b0;
                op_oper_r    <= win_s ? oper1 : oper0;
                op_sign_r    <= win_s ? sign1 : sign0;
                owner_r      <= win_s;
                last_grant_r <= win_s;
            end
            if (finish_s) begin
                result_r <= alu_result;
            end
        end
    end

    assign gnt0   = gnt0_r;
    assign gnt1   = gnt1_r;
    assign done0  = done0_r;
    assign done1  = done1_r;
    assign result = result_r;
    assign busy   = (state_r == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Runs a round-robin (FAIR=1) and a fixed-priority (FAIR=0) arbiter side by
// side on the same requester stimulus. Each has its own behavioural ALU. A
// transaction-level reference model predicts every output at each cycle.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;

    logic        clk, rst, req0, req1, flush, sign0, sign1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  oper0, oper1;

    logic [31:0] alu_a_f, alu_b_f, alu_res_f, result_f;
    logic [3:0]  alu_oper_f;
    logic        alu_sign_f, gnt0_f, gnt1_f, done0_f, done1_f, busy_f;
    logic [31:0] alu_a_p, alu_b_p, alu_res_p, result_p;
    logic [3:0]  alu_oper_p;
    logic        alu_sign_p, gnt0_p, gnt1_p, done0_p, done1_p, busy_p;

    int vectors;
    int miscompares;

    // Reference model state, index 0 = FAIR=1 instance, 1 = FAIR=0 instance
    logic        m_exec [2];
    logic [31:0] m_a [2];
    logic [31:0] m_b [2];
    logic [31:0] m_res [2];
    logic [3:0]  m_op [2];
    logic        m_sg [2];
    logic        m_own [2];
    logic        m_last [2];
    logic        m_g0 [2];
    logic        m_g1 [2];
    logic        m_d0 [2];
    logic        m_d1 [2];

    logic [105:0] obs [2];

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op, input logic s);
        logic [31:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = s ? {31'd0, ($signed(a) < $signed(b))} : {31'd0, (a < b)};
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = s ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign alu_res_f = alu_fn(alu_a_f, alu_b_f, alu_oper_f, alu_sign_f);
    assign alu_res_p = alu_fn(alu_a_p, alu_b_p, alu_oper_p, alu_sign_p);

    assign obs[0] = {gnt0_f, gnt1_f, done0_f, done1_f, busy_f, result_f,
                     alu_a_f, alu_b_f, alu_oper_f, alu_sign_f};
    assign obs[1] = {gnt0_p, gnt1_p, done0_p, done1_p, busy_p, result_p,
                     alu_a_p, alu_b_p, alu_oper_p, alu_sign_p};

    alu_arbiter #(.FAIR(1)) dut_f (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .oper0(oper0), .oper1(oper1), .sign0(sign0), .sign1(sign1),
        .flush(flush),
        .alu_a(alu_a_f), .alu_b(alu_b_f), .alu_oper(alu_oper_f), .alu_sign(alu_sign_f),
        .alu_result(alu_res_f),
        .gnt0(gnt0_f), .gnt1(gnt1_f), .done0(done0_f), .done1(done1_f),
        .result(result_f), .busy(busy_f)
    );

    alu_arbiter #(.FAIR(0)) dut_p (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .oper0(oper0), .oper1(oper1), .sign0(sign0), .sign1(sign1),
        .flush(flush),
        .alu_a(alu_a_p), .alu_b(alu_b_p), .alu_oper(alu_oper_p), .alu_sign(alu_sign_p),
        .alu_result(alu_res_p),
        .gnt0(gnt0_p), .gnt1(gnt1_p), .done0(done0_p), .done1(done1_p),
        .result(result_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    // Expected observation vector for instance k
    function automatic logic [105:0] exp_vec(input int k);
        return {m_g0[k], m_g1[k], m_d0[k], m_d1[k], m_exec[k], m_res[k],
                m_exec[k] ? m_a[k] : 32'd0, m_exec[k] ? m_b[k] : 32'd0,
                m_exec[k] ? m_op[k] : 4'd0, m_exec[k] ? m_sg[k] : 1'b0};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_exec[k] = 1'b0; m_a[k] = 32'd0; m_b[k] = 32'd0; m_res[k] = 32'd0;
            m_op[k] = 4'd0; m_sg[k] = 1'b0; m_own[k] = 1'b0; m_last[k] = 1'b1;
            m_g0[k] = 1'b0; m_g1[k] = 1'b0; m_d0[k] = 1'b0; m_d1[k] = 1'b0;
        end
    endtask

    // One rising edge of the model: finish an operation, or accept a new one
    task automatic model_edge();
        logic w;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_g0[k] = 1'b0; m_g1[k] = 1'b0; m_d0[k] = 1'b0; m_d1[k] = 1'b0;
                if (m_exec[k]) begin
                    if (!flush) begin
                        m_res[k] = alu_fn(m_a[k], m_b[k], m_op[k], m_sg[k]);
                        if (m_own[k]) m_d1[k] = 1'b1;
                        else          m_d0[k] = 1'b1;
                    end
                    m_exec[k] = 1'b0;
                end else if (!flush && (req0 || req1)) begin
                    if (req0 && req1) w = (k == 0) ? !m_last[k] : 1'b0;
                    else              w = req1;
                    m_a[k]  = w ? a1 : a0;
                    m_b[k]  = w ? b1 : b0;
                    m_op[k] = w ? oper1 : oper0;
                    m_sg[k] = w ? sign1 : sign0;
                    m_own[k] = w; m_last[k] = w; m_exec[k] = 1'b1;
                    if (w) m_g1[k] = 1'b1;
                    else   m_g0[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL reset_async dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
        req0 = 1'b1; req1 = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL reset_hold dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({gnt0_f, gnt1_f} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_first_contention got=%b exp=%b", {gnt0_f, gnt1_f}, 2'b10);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL reset_done dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_single_add();
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; oper0 = OP_ADD; sign0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            req0 = 1'b0;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL add_cycle%0d dut%0d got=%h exp=%h", c, k, obs[k], exp_vec(k));
                end
            end
            if (c == 1) begin
                vectors++;
                if ({done0_f, busy_f, result_f} !== {1'b1, 1'b0, 32'd12}) begin
                    miscompares++;
                    $display("FAIL add_result got=%b/%b/%0d exp=1/0/12", done0_f, busy_f, result_f);
                end
            end
        end
    endtask

    task automatic test_contention();
        int g0f, g1f, g0p, g1p;
        g0f = 0; g1f = 0; g0p = 0; g1p = 0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = $urandom; b0 = $urandom; oper0 = OP_ADD; sign0 = 1'b0;
        a1 = 32'hFFFF_FFFF; b1 = 32'd1; oper1 = OP_SUB; sign1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            g0f += int'(gnt0_f); g1f += int'(gnt1_f);
            g0p += int'(gnt0_p); g1p += int'(gnt1_p);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL contend_cycle%0d dut%0d got=%h exp=%h", c, k, obs[k], exp_vec(k));
                end
            end
            if (done1_f) begin
                vectors++;
                if (result_f !== 32'hFFFF_FFFE) begin
                    miscompares++;
                    $display("FAIL contend_sub got=%h exp=%h", result_f, 32'hFFFF_FFFE);
                end
            end
        end
        vectors++;
        if ({g0f, g1f, g0p, g1p} !== {32'd2, 32'd2, 32'd4, 32'd0}) begin
            miscompares++;
            $display("FAIL contend_counts got=%0d,%0d,%0d,%0d exp=2,2,4,0", g0f, g1f, g0p, g1p);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_slt();
        for (int s = 1; s >= 0; s--) begin
            req0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'd1; oper0 = OP_SLT; sign0 = s[0];
            tick();
            req0 = 1'b0;
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL slt_sign%0d dut%0d got=%h exp=%h", s, k, obs[k], exp_vec(k));
                end
            end
            vectors++;
            if (result_f !== {31'd0, s[0]}) begin
                miscompares++;
                $display("FAIL slt_result sign=%0d got=%0d exp=%0d", s, result_f, s);
            end
        end
    endtask

    task automatic test_flush();
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; oper0 = OP_ADD; sign0 = 1'b0;
        tick();
        req0 = 1'b0;
        tick();
        req0 = 1'b1; a0 = 32'd100; b0 = 32'd1;
        tick();
        req0 = 1'b0; flush = 1'b1;
        tick();
        vectors++;
        if ({done0_f, done1_f, busy_f, result_f} !== {3'b000, 32'd12}) begin
            miscompares++;
            $display("FAIL flush_exec got=%b%b%b/%0d exp=000/12", done0_f, done1_f, busy_f, result_f);
        end
        req1 = 1'b1; a1 = 32'd3; b1 = 32'd4; oper1 = OP_ADD; sign1 = 1'b0;
        tick();
        vectors++;
        if ({gnt0_f, gnt1_f, busy_f} !== 3'b000) begin
            miscompares++;
            $display("FAIL flush_idle got=%b exp=000", {gnt0_f, gnt1_f, busy_f});
        end
        flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            req1 = 1'b0;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL flush_after%0d dut%0d got=%h exp=%h", c, k, obs[k], exp_vec(k));
                end
            end
        end
        vectors++;
        if ({done1_f, result_f} !== {1'b1, 32'd7}) begin
            miscompares++;
            $display("FAIL flush_resume got=%b/%0d exp=1/7", done1_f, result_f);
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; a0 = 32'd9; b0 = 32'd9; oper0 = OP_ADD;
        tick();
        req0 = 1'b0; rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL rstmid_async dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
        @(negedge clk);
        tick();
        req0 = 1'b1; req1 = 1'b1; rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            req0 = 1'b0; req1 = 1'b0;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL rstmid_after%0d dut%0d got=%h exp=%h", c, k, obs[k], exp_vec(k));
                end
            end
            if (c == 0) begin
                vectors++;
                if ({gnt0_f, gnt1_f} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL rstmid_contention got=%b exp=%b", {gnt0_f, gnt1_f}, 2'b10);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            oper0 = 4'($urandom_range(0, 7)); oper1 = 4'($urandom_range(0, 7));
            sign0 = 1'($urandom_range(0, 1)); sign1 = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 7) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL random%0d dut%0d got=%h exp=%h", c, k, obs[k], exp_vec(k));
                end
            end
        end
        flush = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; flush = 1'b0;
        req0 = 1'b0; req1 = 1'b0; sign0 = 1'b0; sign1 = 1'b0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        oper0 = 4'd0; oper1 = 4'd0;
        vectors = 0; miscompares = 0;
        test_reset();
        test_single_add();
        test_contention();
        test_slt();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
